pss_mem_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares one memory port of the PSS memory-split subsystem between the UART debug master (m0) and the CPU data port (m1). It uses the team's req/ack/resp bus: req+ack accepts a transfer, and a read later returns resp with rdata. Only one read may be outstanding. A watchdog completes a read that gets no response, so the debug path cannot hang.

---
 rtl/pss_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_pss_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pss_mem_arbiter.sv
// Two-master req/ack/resp arbiter sharing one PSS memory port between the
// UART debug master (m0) and the CPU data port (m1). One read outstanding at
// a time. A watchdog force-completes a read whose response never arrives.
module pss_mem_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter bit                RR_EN    = 1'b1,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ack_o,
  output logic                m0_resp_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ack_o,
  output logic                m1_resp_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                timeout_o
);

  localparam int unsigned TMR_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               prio_q;     // 0 = m0 preferred, 1 = m1 preferred
  logic               owner_q;    // master that issued the outstanding read
  logic [TMR_W-1:0]   timer_q;
  logic               to_q;       // forced completion is presented this cycle
  logic [DATA_W-1:0]  rdata0_q;
  logic [DATA_W-1:0]  rdata1_q;

  logic               winner;
  logic               sel_req;
  logic               sel_we;
  logic               accept;
  logic               rd_done;
  logic               expire;

  // Grant selection: a lone requester wins; on contention RR pointer or m0.
  always_comb begin
    winner = 1'b0;
    if (m0_req_i && m1_req_i) begin
      winner = RR_EN ? prio_q : 1'b0;
    end else if (m1_req_i) begin
      winner = 1'b1;
    end
    sel_req = winner ? m1_req_i : m0_req_i;
    sel_we  = winner ? m1_we_i  : m0_we_i;
  end

  assign accept  = (state_q == IDLE) && sel_req && s_ack_i;
  assign rd_done = (state_q == WAIT_RESP) && s_resp_i;
  assign expire  = (TIMEOUT != 0) && (state_q == WAIT_RESP) && !s_resp_i &&
                   (timer_q == TMR_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accepted read waits for its response; response or expiry ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && !sel_we) state_d = WAIT_RESP;
      WAIT_RESP: if (rd_done || expire) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Priority pointer, read owner, watchdog timer and per-master read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      timer_q  <= '0;
      to_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      to_q <= expire;
      if (accept) begin
        prio_q <= ~winner;
        if (!sel_we) begin
          owner_q <= winner;
          timer_q <= '0;
        end
      end else if ((state_q == WAIT_RESP) && (timer_q != TMR_MAX)) begin
        timer_q <= timer_q + TMR_W'(1);
      end
      if (rd_done || expire) begin
        if (owner_q) begin
          rdata1_q <= rd_done ? s_rdata_i : ERR_DATA;
        end else begin
          rdata0_q <= rd_done ? s_rdata_i : ERR_DATA;
        end
      end
    end
  end

  // Outputs: slave forwarding and acks in IDLE, response routing to the owner.
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = m0_we_i;
    s_addr_o   = m0_addr_i;
    s_be_o     = m0_be_i;
    s_wdata_o  = m0_wdata_i;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    if (winner) begin
      s_we_o    = m1_we_i;
      s_addr_o  = m1_addr_i;
      s_be_o    = m1_be_i;
      s_wdata_o = m1_wdata_i;
    end
    if (state_q == IDLE) begin
      s_req_o  = sel_req;
      m0_ack_o = !winner && sel_req && s_ack_i;
      m1_ack_o =  winner && sel_req && s_ack_i;
    end
    m0_resp_o  = !owner_q && (rd_done || to_q);
    m1_resp_o  =  owner_q && (rd_done || to_q);
    m0_rdata_o = (rd_done && !owner_q) ? s_rdata_i : rdata0_q;
    m1_rdata_o = (rd_done &&  owner_q) ? s_rdata_i : rdata1_q;
    timeout_o  = to_q;
  end

endmodule

// File: tb/tb_pss_mem_arbiter.sv
// Bench for pss_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. dut0 is round-robin, dut1 fixed.
module tb_pss_mem_arbiter;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        m0_req   [2];
  logic        m0_we    [2];
  logic [31:0] m0_addr  [2];
  logic [3:0]  m0_be    [2];
  logic [31:0] m0_wdata [2];
  logic        m0_ack   [2];
  logic        m0_resp  [2];
  logic [31:0] m0_rdata [2];
  logic        m1_req   [2];
  logic        m1_we    [2];
  logic [31:0] m1_addr  [2];
  logic [3:0]  m1_be    [2];
  logic [31:0] m1_wdata [2];
  logic        m1_ack   [2];
  logic        m1_resp  [2];
  logic [31:0] m1_rdata [2];
  logic        s_req    [2];
  logic        s_we     [2];
  logic [31:0] s_addr   [2];
  logic [3:0]  s_be     [2];
  logic [31:0] s_wdata  [2];
  logic        s_ack    [2];
  logic        s_resp   [2];
  logic [31:0] s_rdata  [2];
  logic        timeout  [2];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pss_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RR_EN(1'(g == 0)), .TIMEOUT(TO), .ERR_DATA(ERR)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[g]),
      .m0_req_i(m0_req[g]), .m0_we_i(m0_we[g]), .m0_addr_i(m0_addr[g]),
      .m0_be_i(m0_be[g]), .m0_wdata_i(m0_wdata[g]), .m0_ack_o(m0_ack[g]),
      .m0_resp_o(m0_resp[g]), .m0_rdata_o(m0_rdata[g]),
      .m1_req_i(m1_req[g]), .m1_we_i(m1_we[g]), .m1_addr_i(m1_addr[g]),
      .m1_be_i(m1_be[g]), .m1_wdata_i(m1_wdata[g]), .m1_ack_o(m1_ack[g]),
      .m1_resp_o(m1_resp[g]), .m1_rdata_o(m1_rdata[g]),
      .s_req_o(s_req[g]), .s_we_o(s_we[g]), .s_addr_o(s_addr[g]),
      .s_be_o(s_be[g]), .s_wdata_o(s_wdata[g]), .s_ack_i(s_ack[g]),
      .s_resp_i(s_resp[g]), .s_rdata_i(s_rdata[g]), .timeout_o(timeout[g])
    );
  end

  task automatic idle_inputs(input int d);
    m0_req[d] = 1'b0; m0_we[d] = 1'b0; m0_addr[d] = '0; m0_be[d] = '0; m0_wdata[d] = '0;
    m1_req[d] = 1'b0; m1_we[d] = 1'b0; m1_addr[d] = '0; m1_be[d] = '0; m1_wdata[d] = '0;
    s_ack[d] = 1'b0; s_resp[d] = 1'b0; s_rdata[d] = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    idle_inputs(d);
    rst[d] = 1'b1;
    next_cycle();
    next_cycle();
    rst[d] = 1'b0;
  endtask

  task automatic both_write(input int d);
    m0_req[d] = 1'b1; m0_we[d] = 1'b1; m0_addr[d] = 32'hA0; m0_be[d] = 4'hF; m0_wdata[d] = 32'h1;
    m1_req[d] = 1'b1; m1_we[d] = 1'b1; m1_addr[d] = 32'hB0; m1_be[d] = 4'hF; m1_wdata[d] = 32'h2;
    s_ack[d]  = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      rst[d] = 1'b1;
    end
    next_cycle();
    next_cycle();
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ctl = {m0_ack[d], m1_ack[d], m0_resp[d], m1_resp[d], s_req[d], timeout[d]};
      n_chk++;
      if (ctl !== 6'b0) begin
        n_err++;
        $display("FAIL reset_ctrl dut%0d got %b want 000000", d, ctl);
      end
      n_chk++;
      if (m0_rdata[d] !== 32'h0 || m1_rdata[d] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_rdata dut%0d got %h/%h want 0/0", d, m0_rdata[d], m1_rdata[d]);
      end
    end
    next_cycle();
  endtask

  task automatic test_rr_contention();
    logic e0;
    do_reset(0);
    both_write(0);
    for (int k = 0; k < 8; k++) begin
      e0 = (k % 2 == 0);
      @(negedge clk);
      n_chk++;
      if (m0_ack[0] !== e0 || m1_ack[0] !== !e0) begin
        n_err++;
        $display("FAIL rr_grant k=%0d got ack0=%b ack1=%b want ack0=%b ack1=%b",
                 k, m0_ack[0], m1_ack[0], e0, !e0);
      end
      n_chk++;
      if (s_addr[0] !== (e0 ? 32'hA0 : 32'hB0)) begin
        n_err++;
        $display("FAIL rr_addr k=%0d got %h want %h", k, s_addr[0], e0 ? 32'hA0 : 32'hB0);
      end
      next_cycle();
    end
    idle_inputs(0);
  endtask

  task automatic test_fixed_prio();
    do_reset(1);
    both_write(1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (m0_ack[1] !== 1'b1 || m1_ack[1] !== 1'b0 || s_addr[1] !== 32'hA0) begin
        n_err++;
        $display("FAIL fixed_m0 k=%0d got ack0=%b ack1=%b addr=%h want 1 0 a0",
                 k, m0_ack[1], m1_ack[1], s_addr[1]);
      end
      next_cycle();
    end
    m0_req[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m1_ack[1] !== 1'b1 || m0_ack[1] !== 1'b0 || s_addr[1] !== 32'hB0) begin
      n_err++;
      $display("FAIL fixed_m1 got ack0=%b ack1=%b addr=%h want 0 1 b0",
               m0_ack[1], m1_ack[1], s_addr[1]);
    end
    next_cycle();
    idle_inputs(1);
  endtask

  task automatic test_read_routing();
    do_reset(0);
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h100; s_ack[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (m1_ack[0] !== 1'b1 || m0_ack[0] !== 1'b0 || s_addr[0] !== 32'h100 || s_we[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rd_ack got ack1=%b ack0=%b addr=%h we=%b want 1 0 100 0",
               m1_ack[0], m0_ack[0], s_addr[0], s_we[0]);
    end
    next_cycle();
    m1_req[0] = 1'b0;
    m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 32'h200;
    for (int w = 1; w <= 3; w++) begin
      if (w == 3) begin
        s_resp[0] = 1'b1; s_rdata[0] = 32'h12345678;
      end
      @(negedge clk);
      n_chk++;
      if (m0_ack[0] !== 1'b0 || s_req[0] !== 1'b0) begin
        n_err++;
        $display("FAIL rd_wait_block w=%0d got ack0=%b sreq=%b want 0 0", w, m0_ack[0], s_req[0]);
      end
      n_chk++;
      if (m1_resp[0] !== (w == 3) || m0_resp[0] !== 1'b0) begin
        n_err++;
        $display("FAIL rd_resp w=%0d got resp1=%b resp0=%b want %b 0", w, m1_resp[0], m0_resp[0], w == 3);
      end
      if (w == 3) begin
        n_chk++;
        if (m1_rdata[0] !== 32'h12345678) begin
          n_err++;
          $display("FAIL rd_data got %h want 12345678", m1_rdata[0]);
        end
      end
      next_cycle();
    end
    s_resp[0] = 1'b0; s_rdata[0] = 32'h0;
    @(negedge clk);
    n_chk++;
    if (m0_ack[0] !== 1'b1 || s_addr[0] !== 32'h200 || m1_resp[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rd_after got ack0=%b addr=%h resp1=%b want 1 200 0", m0_ack[0], s_addr[0], m1_resp[0]);
    end
    n_chk++;
    if (m1_rdata[0] !== 32'h12345678 || m0_rdata[0] !== 32'h0) begin
      n_err++;
      $display("FAIL rd_hold got %h/%h want 12345678/0", m1_rdata[0], m0_rdata[0]);
    end
    next_cycle();
    idle_inputs(0);
  endtask

  task automatic test_timeout();
    do_reset(0);
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h40; s_ack[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (m0_ack[0] !== 1'b1) begin
      n_err++;
      $display("FAIL to_ack got %b want 1", m0_ack[0]);
    end
    next_cycle();
    m0_req[0] = 1'b0; s_ack[0] = 1'b0;
    for (int w = 1; w <= int'(TO); w++) begin
      @(negedge clk);
      n_chk++;
      if (timeout[0] !== 1'b0 || m0_resp[0] !== 1'b0) begin
        n_err++;
        $display("FAIL to_early w=%0d got to=%b resp0=%b want 0 0", w, timeout[0], m0_resp[0]);
      end
      next_cycle();
    end
    @(negedge clk);
    n_chk++;
    if (timeout[0] !== 1'b1 || m0_resp[0] !== 1'b1 || m1_resp[0] !== 1'b0) begin
      n_err++;
      $display("FAIL to_pulse got to=%b resp0=%b resp1=%b want 1 1 0", timeout[0], m0_resp[0], m1_resp[0]);
    end
    n_chk++;
    if (m0_rdata[0] !== ERR) begin
      n_err++;
      $display("FAIL to_data got %h want %h", m0_rdata[0], ERR);
    end
    next_cycle();
    s_resp[0] = 1'b1; s_rdata[0] = 32'h55;
    @(negedge clk);
    n_chk++;
    if (timeout[0] !== 1'b0 || m0_resp[0] !== 1'b0 || m1_resp[0] !== 1'b0 || m0_rdata[0] !== ERR) begin
      n_err++;
      $display("FAIL to_late got to=%b resp0=%b resp1=%b data=%h want 0 0 0 %h",
               timeout[0], m0_resp[0], m1_resp[0], m0_rdata[0], ERR);
    end
    next_cycle();
    idle_inputs(0);
  endtask

  task automatic test_reset_mid_read();
    do_reset(0);
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h80; s_ack[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (m0_ack[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_ack got %b want 1", m0_ack[0]);
    end
    next_cycle();
    idle_inputs(0);
    next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    s_resp[0] = 1'b1; s_rdata[0] = 32'h77;
    @(negedge clk);
    n_chk++;
    if (m0_resp[0] !== 1'b0 || m1_resp[0] !== 1'b0 || timeout[0] !== 1'b0 || m0_rdata[0] !== 32'h0) begin
      n_err++;
      $display("FAIL mid_stray got resp0=%b resp1=%b to=%b data=%h want 0 0 0 0",
               m0_resp[0], m1_resp[0], timeout[0], m0_rdata[0]);
    end
    next_cycle();
    s_resp[0] = 1'b0;
    both_write(0);
    @(negedge clk);
    n_chk++;
    if (m0_ack[0] !== 1'b1 || m1_ack[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_prio got ack0=%b ack1=%b want 1 0", m0_ack[0], m1_ack[0]);
    end
    next_cycle();
    idle_inputs(0);
  endtask

  // Random traffic; the model tracks "is a read outstanding, by whom, how many
  // cycles of patience are left" and who is owed the next turn.
  task automatic test_random(input int d, input int cycles);
    bit          busy, owner, prio, to_pend, rr, w, e_sreq, e_live, drop0, drop1;
    int          left;
    logic [31:0] mrd [2];
    logic [5:0]  e_ctl, g_ctl;
    logic [68:0] e_fwd, g_fwd;
    logic [31:0] e_rd0, e_rd1;
    rr = (d == 0);
    do_reset(d);
    busy = 0; owner = 0; prio = 0; to_pend = 0; left = 0; mrd[0] = '0; mrd[1] = '0;
    drop0 = 0; drop1 = 0;
    for (int c = 0; c < cycles; c++) begin
      if (drop0) m0_req[d] = 1'b0;
      if (drop1) m1_req[d] = 1'b0;
      rst[d] = ($urandom_range(0, 63) == 0);
      if (rst[d]) begin
        m0_req[d] = 1'b0; m1_req[d] = 1'b0;
      end else begin
        if (!m0_req[d] && $urandom_range(0, 1) == 1) begin
          m0_req[d] = 1'b1; m0_we[d] = 1'($urandom_range(0, 1));
          m0_addr[d] = $urandom; m0_be[d] = 4'($urandom); m0_wdata[d] = $urandom;
        end
        if (!m1_req[d] && $urandom_range(0, 1) == 1) begin
          m1_req[d] = 1'b1; m1_we[d] = 1'($urandom_range(0, 1));
          m1_addr[d] = $urandom; m1_be[d] = 4'($urandom); m1_wdata[d] = $urandom;
        end
      end
      s_ack[d]   = ($urandom_range(0, 3) != 0);
      s_resp[d]  = ($urandom_range(0, 3) == 0);
      s_rdata[d] = $urandom;
      @(negedge clk);
      if (m0_req[d] && m1_req[d]) w = rr ? prio : 1'b0;
      else w = m1_req[d];
      e_sreq = !busy && (m0_req[d] || m1_req[d]);
      e_live = busy && s_resp[d];
      e_ctl  = {e_sreq && !w && s_ack[d], e_sreq && w && s_ack[d], e_sreq,
                (e_live || to_pend) && !owner, (e_live || to_pend) && owner, to_pend};
      e_rd0  = (e_live && !owner) ? s_rdata[d] : mrd[0];
      e_rd1  = (e_live &&  owner) ? s_rdata[d] : mrd[1];
      e_fwd  = w ? {m1_we[d], m1_addr[d], m1_be[d], m1_wdata[d]}
                 : {m0_we[d], m0_addr[d], m0_be[d], m0_wdata[d]};
      if (!rst[d]) begin
        g_ctl = {m0_ack[d], m1_ack[d], s_req[d], m0_resp[d], m1_resp[d], timeout[d]};
        n_chk++;
        if (g_ctl !== e_ctl) begin
          n_err++;
          $display("FAIL rand_ctl dut%0d c=%0d got %b want %b (ack0 ack1 sreq resp0 resp1 to)",
                   d, c, g_ctl, e_ctl);
        end
        n_chk++;
        if (m0_rdata[d] !== e_rd0 || m1_rdata[d] !== e_rd1) begin
          n_err++;
          $display("FAIL rand_rdata dut%0d c=%0d got %h/%h want %h/%h",
                   d, c, m0_rdata[d], m1_rdata[d], e_rd0, e_rd1);
        end
        if (e_sreq) begin
          g_fwd = {s_we[d], s_addr[d], s_be[d], s_wdata[d]};
          n_chk++;
          if (g_fwd !== e_fwd) begin
            n_err++;
            $display("FAIL rand_fwd dut%0d c=%0d got %h want %h", d, c, g_fwd, e_fwd);
          end
        end
      end
      drop0 = 0; drop1 = 0;
      if (rst[d]) begin
        busy = 0; owner = 0; prio = 0; to_pend = 0; mrd[0] = '0; mrd[1] = '0;
      end else begin
        to_pend = 0;
        if (e_sreq && s_ack[d]) begin
          prio = !w;
          if (w) drop1 = 1; else drop0 = 1;
          if (!e_fwd[68]) begin
            busy = 1; owner = w; left = int'(TO);
          end
        end else if (busy) begin
          if (s_resp[d]) begin
            busy = 0; mrd[owner] = s_rdata[d];
          end else if (TO != 0) begin
            left--;
            if (left == 0) begin
              busy = 0; to_pend = 1; mrd[owner] = ERR;
            end
          end
        end
      end
      next_cycle();
    end
    rst[d] = 1'b0;
    idle_inputs(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      idle_inputs(d);
    end
    next_cycle();
    test_reset();
    test_rr_contention();
    test_fixed_prio();
    test_read_routing();
    test_timeout();
    test_reset_mid_read();
    test_random(0, 600);
    test_random(1, 600);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
